ram_responder: RTL and testbench
================================

# ram_responder

Synthesizable responder end of the on-chip RAM access interface: accepts single-word read/write requests on a valid/ready request channel, stores data in an internal 2^ADDR_W x DATA_W array, and returns read data on a valid/ready response channel with a one-deep output register. It also runs a hardware clear sweep after reset or on command. It is the slave that a RAM-driving initiator (sequencer, bus bridge, or bench) talks to, in place of a bare ena/wena port RAM.

## Interface
- ADDR_W, 5: address width; depth = 2^ADDR_W (32 words).
- DATA_W, 32: data width.
- CLR_VAL, 0: value written to every word by a clear sweep.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- clr  in  1  single-cycle pulse; start a clear sweep.
- rsp_valid  out  1  read data present.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_rdata  out  DATA_W  read data; stable while rsp_valid && !rsp_ready.
- busy  out  1  clear sweep in progress.

## Operation
- States: CLEAR, IDLE.
- rst asserted: state = CLEAR, sweep counter = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 0, busy = 1. Array contents are not reset by rst; the sweep clears them.
- CLEAR: each cycle writes CLR_VAL to mem[counter], counter increments; after writing address 2^ADDR_W-1 (32 cycles), state -> IDLE, busy -> 0. No requests accepted (req_ready = 0). A pending response stays held and can still be consumed during CLEAR.
- IDLE: req_ready = !clr && (!rsp_valid || rsp_ready). Handshake = req_valid && req_ready.
- Accepted write: mem[req_addr] <= req_wdata at that edge; no response generated.
- Accepted read: at that edge rsp_rdata <= mem[req_addr], rsp_valid <= 1.
- rsp_valid clears at an edge with rsp_ready = 1 and no new read accepted; if a read is accepted in the same cycle the response is consumed, rsp_valid stays 1 with the new data (back-to-back).
- clr in IDLE: state -> CLEAR, counter = 0, busy = 1 next cycle; any request that cycle is not accepted (req_ready = 0 forced by clr). clr during CLEAR is ignored (sweep is not restarted).
- Read of an address written in an earlier cycle returns the new data; a read and write cannot coincide (one request per cycle).
- Addresses wrap naturally within ADDR_W; no out-of-range case exists.

## Timing
- Read latency: response valid 1 cycle after acceptance edge.
- Throughput: 1 request/cycle when rsp_ready held high.
- Backpressure: rsp_valid && !rsp_ready holds req_ready low; response register and rsp_rdata unchanged until consumed.
- Post-reset: busy high for exactly 32 cycles after first edge following rst deassert; req_ready may first be 1 in the 33rd cycle.
- Clear sweep after clr: same 32 cycles; busy rises on the edge that samples clr.
- Reset mid-sweep or mid-response: async drop of rsp_valid, sweep restarts from address 0 after deassert.

## Test plan
- Reset, release: busy = 1 for 32 cycles, req_ready = 0 throughout, then busy = 0, req_ready = 1; read all 32 addresses -> every rsp_rdata = 0.
- Write addr k data k+1 for k = 0..30 back-to-back, then read 0..30 with rsp_ready = 1 -> one response per cycle, rsp_rdata = k+1, latency 1; address 31 reads 0.
- Read addr 3 (holding 0x0000_0004) with rsp_ready = 0 for 5 cycles -> rsp_valid held, rsp_rdata = 4 stable, req_ready = 0; raise rsp_ready -> consumed, req_ready = 1 same cycle.
- Write addr 7 = 0xDEAD_BEEF, next cycle read addr 7 -> 0xDEAD_BEEF.
- Pulse clr with req_valid = 1 same cycle -> request not accepted, busy 32 cycles, then all reads return CLR_VAL; clr pulsed mid-sweep does not lengthen busy.
- Assert rst while rsp_valid = 1 and mid-sweep -> rsp_valid and rsp_rdata 0 immediately, full 32-cycle sweep after release.

Source files
------------

// File: rtl/ram_responder.sv
// Single-port word RAM behind a valid/ready request channel and a one-deep
// registered read-response channel, with a hardware clear sweep after reset or clr.
module ram_responder #(
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;

  // A held response blocks new requests so it can never be overwritten.
  assign req_ready = (state == IDLE) && !clr && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign wr_accept = accept && req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase

      if (rd_accept) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem[req_addr];
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Array has no reset; the sweep owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= CLR_VAL;
    else if (wr_accept)
      mem[req_addr] <= req_wdata;
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: driver queues expected read data,
// a negedge monitor pops and compares on every response handshake.
module tb_ram_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        clr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_q [$];

  ram_responder #(
    .ADDR_W (5),
    .DATA_W (32),
    .CLR_VAL(32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .clr      (clr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the oldest queued expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got %h, required no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_rdata !== e) begin
            errors++;
            $display("FAIL rsp_data: got %h, required %h", rsp_rdata, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; waits (bounded) for the handshake.
  task automatic issue(input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int unsigned i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        if (!we) exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("req_accept", {31'd0, ok}, 32'd1);
    if (!we && ok) check("rd_latency", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic sweep_check(input int unsigned clr_at);
    int unsigned n;
    logic bad;
    logic done;
    n = 0; bad = 1'b0; done = 1'b0;
    for (int unsigned i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      clr = 1'b0;
      if (!busy) done = 1'b1;
      else begin
        n++;
        if (req_ready) bad = 1'b1;
        if (n == clr_at) clr = 1'b1;
      end
    end
    check("busy_cycles", n, 32'd32);
    check("ready_in_sweep", {31'd0, bad}, 32'd0);
    check("ready_after_sweep", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; clr = 1'b0; rsp_ready = 1'b1;

    // Reset state and post-reset sweep
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_check(0);

    for (int unsigned k = 0; k < 32; k++) issue(1'b0, 5'(k), '0, 32'd0);

    // Back-to-back writes k -> k+1, then reads; address 31 stays cleared
    for (int unsigned k = 0; k < 31; k++) issue(1'b1, 5'(k), 32'(k + 1), '0);
    for (int unsigned k = 0; k < 31; k++) issue(1'b0, 5'(k), '0, 32'(k + 1));
    issue(1'b0, 5'd31, '0, 32'd0);
    idle(2);

    // Backpressure on a read of addr 3
    rsp_ready = 1'b0;
    issue(1'b0, 5'd3, '0, 32'd4);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'd4);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    issue(1'b1, 5'd7, 32'hDEAD_BEEF, '0);
    issue(1'b0, 5'd7, '0, 32'hDEAD_BEEF);
    idle(2);

    // clr with a simultaneous read request, plus a mid-sweep clr
    clr = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
    @(negedge clk);
    check("clr_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; req_valid = 1'b0;
    sweep_check(10);
    for (int unsigned k = 0; k < 32; k++) issue(1'b0, 5'(k), '0, 32'd0);
    idle(2);

    // Reset while a response is held and a sweep is running
    issue(1'b1, 5'd7, 32'h0000_A5A5, '0);
    rsp_ready = 1'b0;
    issue(1'b0, 5'd7, '0, 32'h0000_A5A5);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    idle(3);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rsp_rdata", rsp_rdata, 32'd0);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_check(0);
    issue(1'b0, 5'd7, '0, 32'd0);
    issue(1'b0, 5'd3, '0, 32'd0);

    idle(3);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
